// File: rtl/cu_pkg.sv
// Shared opcode/state encodings and instruction field helpers
// for the multi-cycle control unit.
package cu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_LDI  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_BEQZ = 4'b1000,
        OP_JMP  = 4'b1001,
        OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam int OP_MSB = 15;
    localparam int RD_MSB = 11;
    localparam int RS_MSB = 7;
    localparam int IMM_W  = 8;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       rf_we_req;
        logic       rf_wsel;
        logic       is_branch;
        logic       is_jmp;
        logic       is_halt;
        logic       illegal;
    } dec_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic writes_rf(input logic [3:0] op);
        return is_alu_op(op) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: ir -> control bundle.
// Undefined opcodes flag illegal and otherwise behave as NOP.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    logic [3:0] op;

    assign op = ir[OP_MSB -: 4];

    always_comb begin
        dec        = '0;
        dec.alu_op = op;
        unique case (1'b1)
            writes_rf(op): begin
                dec.rf_we_req = 1'b1;
                dec.rf_wsel   = (op == OP_LDI);
            end
            (op == OP_BEQZ): dec.is_branch = 1'b1;
            (op == OP_JMP):  dec.is_jmp    = 1'b1;
            (op == OP_HALT): dec.is_halt   = 1'b1;
            (op == OP_NOP):  ;
            default:         dec.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/WB sequencer for the 16-bit RISC core.
// Define CU_INSTR_COUNT_EN to add the saturating instr_count output.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic              rf_wsel,
    output logic [DATA_W-1:0] imm,
    output logic [3:0]        alu_op,
    output logic              busy,
    output logic              halted,
    output logic              retire,
`ifdef CU_INSTR_COUNT_EN
    output logic [31:0]       instr_count,
`endif
    output logic              illegal
);

    state_e          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            taken;
    logic            opnd;
    dec_t            dec;

    cu_decoder u_dec (
        .ir  (ir),
        .dec (dec)
    );

    assign imem_addr = pc;
    assign opnd      = (state == S_EXEC) || (state == S_WB);
    assign rf_raddr1 = opnd ? ir[RD_MSB -: 4] : 4'd0;
    assign rf_raddr2 = opnd ? ir[RS_MSB -: 4] : 4'd0;
    assign alu_op    = opnd ? dec.alu_op : 4'd0;
    assign imm       = opnd ? DATA_W'(ir[IMM_W-1:0]) : '0;
    assign busy      = state inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            taken    <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= 4'd0;
            rf_wsel  <= 1'b0;
            retire   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            rf_we    <= 1'b0;
            rf_waddr <= 4'd0;
            rf_wsel  <= 1'b0;
            retire   <= 1'b0;
            illegal  <= 1'b0;
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                    end
                end
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= imem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // WB pulses are registered here so they line up with WB
                    taken    <= dec.is_jmp
                              | (dec.is_branch & (rf_rdata1 == '0));
                    rf_we    <= dec.rf_we_req;
                    rf_wsel  <= dec.rf_wsel;
                    rf_waddr <= ir[RD_MSB -: 4];
                    retire   <= 1'b1;
                    illegal  <= dec.illegal;
                    state    <= S_WB;
                end
                S_WB: begin
                    pc    <= taken ? ir[PC_W-1:0] : PC_W'(pc + 1'b1);
                    state <= dec.is_halt ? S_HALT : S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CU_INSTR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (start && (state == S_IDLE || state == S_HALT)) begin
            instr_count <= '0;
        end else if (retire && (instr_count != '1)) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: ISA-level reference interpreter vs the control unit,
// with a behavioural instruction memory and register file around it.
module tb_multicycle_control_unit;

    localparam int DATA_W = 8;
    localparam int PC_W   = 3;
    localparam int DEPTH  = 1 << PC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic [3:0]        rf_raddr1;
    logic [3:0]        rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic              rf_wsel;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic              busy;
    logic              halted;
    logic              retire;
    logic              illegal;
`ifdef CU_INSTR_COUNT_EN
    logic [31:0]       instr_count;
`endif

    multicycle_control_unit #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wsel    (rf_wsel),
        .imm        (imm),
        .alu_op     (alu_op),
        .busy       (busy),
        .halted     (halted),
        .retire     (retire),
`ifdef CU_INSTR_COUNT_EN
        .instr_count(instr_count),
`endif
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0]       mem     [DEPTH];
    logic [DATA_W-1:0] rf      [16];
    logic [DATA_W-1:0] rf_init [16];
    logic              rf_load;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] env_wdata;

    function automatic logic [7:0] alu(input logic [3:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        case (op)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    assign rf_rdata1 = rf[rf_raddr1];
    assign rdata2    = rf[rf_raddr2];
    assign env_wdata = rf_wsel ? imm : alu(alu_op, rf_rdata1, rdata2);

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= env_wdata;
        end
    end

    typedef struct {
        int         pc;
        int         op;
        bit         we;
        int         rd;
        bit         wsel;
        logic [7:0] wdata;
        bit         ill;
        bit         halt;
        int         npc;
    } rec_t;

    rec_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_retired;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Architectural interpreter: one record per retired instruction.
    task automatic build_model(input int max_n);
        logic [7:0]  r[16];
        logic [15:0] w;
        logic [7:0]  a, b;
        int          pc;
        rec_t        e;
        q.delete();
        for (int i = 0; i < 16; i++) r[i] = rf_init[i];
        pc = 0;
        for (int n = 0; n < max_n; n++) begin
            w      = mem[pc];
            e.pc   = pc;
            e.op   = int'(w[15:12]);
            e.rd   = int'(w[11:8]);
            e.we   = 0;
            e.wsel = 0;
            e.wdata = 8'd0;
            e.ill  = 0;
            e.halt = 0;
            e.npc  = (pc + 1) % DEPTH;
            a = r[w[11:8]];
            b = r[w[7:4]];
            case (e.op)
                0: ;
                1: begin
                    e.we = 1; e.wsel = 1; e.wdata = w[7:0];
                end
                2, 3, 4, 5, 6: begin
                    e.we = 1;
                    e.wdata = (e.op == 2) ? a + b :
                              (e.op == 3) ? a - b :
                              (e.op == 4) ? a & b :
                              (e.op == 5) ? a | b : a ^ b;
                end
                8:  if (a == 8'd0) e.npc = int'(w[7:0]) % DEPTH;
                9:  e.npc = int'(w[7:0]) % DEPTH;
                15: e.halt = 1;
                default: e.ill = 1;
            endcase
            if (e.we) r[w[11:8]] = e.wdata;
            q.push_back(e);
            if (e.halt) break;
            pc = e.npc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_rf();
        rf_load = 1'b1;
        @(negedge clk);
        rf_load = 1'b0;
    endtask

    // Runs from pc=0 and checks every cycle against the interpreter.
    task automatic run(input int max_n, input bit poke_start);
        rec_t e;
        build_model(max_n);
        load_rf();
        n_retired = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (q[k]) begin
            e = q[k];
            check("fetch_addr", 32'(imem_addr), 32'(e.pc));
            check("fetch_busy", 32'(busy), 32'd1);
`ifdef CU_INSTR_COUNT_EN
            check("instr_count", instr_count, 32'(k));
`endif
            @(negedge clk);
            check("decode_quiet", {30'd0, rf_we, retire}, 32'd0);
            if (poke_start) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            check("exec_quiet", {30'd0, rf_we, retire}, 32'd0);
            check("exec_raddr1", 32'(rf_raddr1), 32'(e.rd));
            @(negedge clk);
            n_retired += int'(retire);
            check("wb_retire", 32'(retire), 32'd1);
            check("wb_illegal", 32'(illegal), 32'(e.ill));
            check("wb_rf_we", 32'(rf_we), 32'(e.we));
            check("wb_alu_op", 32'(alu_op), 32'(e.op));
            check("wb_pc", 32'(imem_addr), 32'(e.pc));
            if (e.we) begin
                check("wb_waddr", 32'(rf_waddr), 32'(e.rd));
                check("wb_wsel", 32'(rf_wsel), 32'(e.wsel));
                check("wb_wdata", 32'(env_wdata), 32'(e.wdata));
            end
            @(negedge clk);
        end
        e = q[q.size()-1];
        if (e.halt) begin
            check("halted", 32'(halted), 32'd1);
            check("halt_busy", 32'(busy), 32'd0);
`ifdef CU_INSTR_COUNT_EN
            check("count_at_halt", instr_count, 32'(q.size()));
`endif
        end else begin
            check("next_fetch", 32'(imem_addr), 32'(e.npc));
            check("still_busy", 32'(busy), 32'd1);
            do_reset();
        end
    endtask

    task automatic set_prog(input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p5);
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
        mem[0] = p0;
        mem[1] = p1;
        mem[5] = p5;
    endtask

    initial begin
        int ops[12];
        ops = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 15, 7, 12};
        rst = 1'b1;
        start = 1'b0;
        rf_load = 1'b0;
        for (int i = 0; i < 16; i++) rf_init[i] = 8'd0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_pulses", {29'd0, rf_we, retire, illegal}, 32'd0);

        // LDI/LDI/ADD/HALT
        mem[0] = 16'h1105; mem[1] = 16'h1203;
        mem[2] = 16'h2120; mem[3] = 16'hF000;
        run(16, 1'b0);
        check("retire_count", 32'(n_retired), 32'd4);

        // Reset in EXEC of the second instruction
        load_rf();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_addr", 32'(imem_addr), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        check("mid_rst_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        check("mid_rst_hold_we", 32'(rf_we), 32'd0);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_addr", 32'(imem_addr), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        do_reset();

        // BEQZ taken / not taken, JMP with truncated target
        set_prog(16'h8105, 16'hF000, 16'hF000);
        rf_init[1] = 8'd0;
        run(8, 1'b0);
        rf_init[1] = 8'd7;
        run(8, 1'b0);
        set_prog(16'h90FD, 16'hF000, 16'hF000);
        run(8, 1'b0);

        // Eight NOPs wrap back to pc=0
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
        run(DEPTH + 1, 1'b0);

        // Illegal opcode
        set_prog(16'h7123, 16'hF000, 16'hF000);
        run(8, 1'b0);

        // Random programs, with start pokes while busy
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = {4'(ops[$urandom_range(0, 11)]),
                          4'($urandom_range(0, 15)),
                          8'($urandom)};
            end
            for (int i = 0; i < 16; i++)
                rf_init[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
            run(24, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle controller for the RISC core.
- Fetches 16-bit instructions from an external instruction memory, decodes them, and sequences register-file reads, ALU operation and writeback.
- Runs FETCH/DECODE/EXEC/WB per instruction, supports branches and halt, and replaces the combinational pc-triggered decode.
- Sits between the instruction memory, `Registers` and `ALU`.

Parameters:
- DATA_W, 8: register/ALU data width; legal range 8..32.
- PC_W, 3: program counter width; program depth is 2**PC_W; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins execution at pc=0 from IDLE or HALT
- imem_addr  out  PC_W  instruction fetch address
- imem_rdata  in  16  instruction word; valid exactly 1 cycle after imem_addr is driven
- rf_raddr1  out  4  register read address A (instr[11:8])
- rf_raddr2  out  4  register read address B (instr[7:4])
- rf_rdata1  in  DATA_W  combinational read data A
- rf_we  out  1  register write enable, single-cycle pulse
- rf_waddr  out  4  register write address
- rf_wsel  out  1  write-data select: 0=ALU result, 1=immediate
- imm  out  DATA_W  instr[7:0], zero-extended
- alu_op  out  4  opcode forwarded to the ALU
- busy  out  1  high from FETCH through WB
- halted  out  1  high while in HALT
- retire  out  1  single-cycle pulse in WB of every completed instruction
- illegal  out  1  single-cycle pulse in WB for an undefined opcode

Behaviour:
- Instruction format:
  - [15:12] opcode, [11:8] rd, [7:4] rs1 (LDI/branch: [7:0] imm/target).
  - ALU ops read rd and rs1 as operands A/B and write rd. This matches the existing two-operand ALU convention.
- Opcodes:
  - 0000 NOP; 0001 LDI; 0010 ADD; 0011 SUB; 0100 AND; 0101 OR; 0110 XOR.
  - 1000 BEQZ: if reg[rd]==0, pc<=target. 1001 JMP: pc<=target.
  - 1111 HALT. All others are illegal and execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Reset enters IDLE.
- IDLE --start--> FETCH with pc=0.
- FETCH: imem_addr=pc; next DECODE.
- DECODE: ir<=imem_rdata; next EXEC.
- EXEC:
  - rf_raddr1/2 and alu_op are driven from ir.
  - Branch condition is sampled from rf_rdata1 this cycle.
  - Next WB.
- WB:
  - rf_we=1 for LDI (rf_wsel=1) and ALU ops 0010..0110 (rf_wsel=0); rf_waddr=rd.
  - retire=1.
  - pc<=target[PC_W-1:0] if the branch is taken, else pc+1 (wraps 2**PC_W-1 -> 0).
  - Next FETCH, or HALT if opcode is 1111.
- HALT: halted=1, busy=0. start -> FETCH with pc=0.
- Timing: 4 cycles per instruction; first retire pulse 4 cycles after the start cycle.
- start while busy=1 is ignored.
- Reset (any cycle, including mid-instruction) immediately forces IDLE. pc, ir and all outputs go to 0; rf_we is never asserted during or after reset.
- rf_raddr/alu_op/imm are held from ir in EXEC and WB; 0 otherwise.
- Branch target wider than PC_W is truncated, not faulted.

Optional Feature:
- Macro: `CU_INSTR_COUNT_EN`.
- Defined:
  - Adds output `instr_count`, 32 bits, reset 0.
  - Increments on every retire pulse, including illegal and HALT.
  - Cleared on start from IDLE/HALT; saturates at 2**32-1.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package `cu_pkg`:
  - opcode enum (4-bit) and state enum.
  - Field-position constants (OP_MSB=15, RD_MSB=11, RS_MSB=7, IMM_W=8).
  - `is_alu_op()` / `writes_rf()` helper functions.
- One sub-module: `cu_decoder`, combinational ir -> {alu_op, rf_we_req, rf_wsel, is_branch, is_jmp, is_halt, illegal}. FSM and pc stay in the top.

Test Plan:
- Reset and idle: assert rst mid-EXEC -> state IDLE, rf_we=0, pc=0, busy=0 in the same cycle. Drive start with rst low -> imem_addr=0 on the next cycle.
- LDI then ADD:
  - Program 0x1105, 0x1203, 0x2120, 0xF000.
  - rf_we pulses with waddr 1/imm 5, waddr 2/imm 3, waddr 1/wsel 0 (ALU).
  - halted=1 after 16 cycles; retire count 4.
- BEQZ taken and not taken:
  - reg1=0, BEQZ r1 -> 5: next imem_addr=5.
  - reg1=7: next imem_addr = pc+1.
- PC wrap: PC_W=3, eight NOPs, no HALT -> after pc=7 retires, imem_addr=0; busy stays 1.
- Illegal opcode 0x7xxx: illegal pulses 1 cycle in WB, rf_we=0, pc advances by 1.
- Counter build (`CU_INSTR_COUNT_EN` defined): run the LDI/ADD program -> instr_count=4 at halt. A new start clears it to 0.
